// File: rtl/spice_node_integrator.sv
// spice_node_integrator
//   Node-voltage stage for the switch-level SPICE emulator. One integration
//   step sums N_IN signed currents into a single accumulator, scales the sum
//   by the node capacitance (arithmetic shift), integrates it into the node
//   voltage and clamps the result to the `LO..`HI rails. The currents are
//   summed serially, one slice per cycle, through one adder, so area does not
//   grow with fan-in.
//
//   Step timeline: start is sampled at edge 0. ACCUM runs on edges 1..N_IN.
//   The scaled sum is registered at edge N_IN+1. v and done update at edge
//   N_IN+2, and the block is back in IDLE at that same edge.
//
// Ports
//   eclk     in   emulation clock, rising edge
//   ereset   in   synchronous active-high reset
//   start    in   request one step; accepted only while ready=1
//   ready    out  high in IDLE only
//   i_in     in   N_IN*`W flat signed currents, slice k = [k*`W +: `W]
//   v        out  registered signed node voltage
//   p        out  logic level of the node (~sign of v)
//   done     out  one-cycle pulse when the new v is valid
//   settled  out  node quiet for SETTLE_COUNT consecutive steps
//   clamped  out  sticky rail-hit flag (only with SPICE_NODE_CLAMP_FLAG_EN)
//
// Optional feature macro: SPICE_NODE_CLAMP_FLAG_EN adds the clamped output.
// Width/rail macros `W, `HI and `LO default to 16 / +16384 / -16384.

`ifndef W
`define W 16
`endif
`ifndef HI
`define HI 16384
`endif
`ifndef LO
`define LO (-16384)
`endif

module spice_node_integrator #(
  parameter int N_IN          = 4,
  parameter int CAP_SHIFT     = 2,
  parameter int SETTLE_THRESH = 0,
  parameter int SETTLE_COUNT  = 3
) (
  input  logic                 eclk,
  input  logic                 ereset,
  input  logic                 start,
  output logic                 ready,
  input  logic [N_IN*`W-1:0]   i_in,
  output logic [`W-1:0]        v,
  output logic                 p,
  output logic                 done,
`ifdef SPICE_NODE_CLAMP_FLAG_EN
  output logic                 clamped,
`endif
  output logic                 settled
);

  // Accumulator is wide enough for N_IN full-scale slices; the voltage sum
  // gets extra headroom so v + delta can never wrap before clamping.
  localparam int AW = `W + $clog2(N_IN) + 1;
  localparam int VW = AW + 2;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = $clog2(SETTLE_COUNT + 1);

  localparam logic signed [VW-1:0] HI_V = VW'(`HI);
  localparam logic signed [VW-1:0] LO_V = VW'(`LO);
  localparam logic signed [`W-1:0] HI_W = `W'(`HI);
  localparam logic signed [`W-1:0] LO_W = `W'(`LO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_p0_q, acc_p0_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]   delta_p1_q, delta_p1_d;
  logic signed [`W-1:0]   v_q, v_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          quiet_q, quiet_d;
`ifdef SPICE_NODE_CLAMP_FLAG_EN
  logic                   clamped_q, clamped_d;
`endif

  logic signed [`W-1:0]   slice_s;
  logic signed [VW-1:0]   vn_s;
  logic signed [`W-1:0]   v_new_s;
  logic signed [VW-1:0]   dv_s;

  function automatic logic signed [`W-1:0] clamp_v(input logic signed [VW-1:0] x);
    if (x > HI_V)      return HI_W;
    else if (x < LO_V) return LO_W;
    else               return x[`W-1:0];
  endfunction

  function automatic logic signed [VW-1:0] abs_v(input logic signed [VW-1:0] x);
    return (x < 0) ? -x : x;
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_p0_d   = acc_p0_q;
    idx_d      = idx_q;
    delta_p1_d = delta_p1_q;
    v_d        = v_q;
    done_d     = 1'b0;
    quiet_d    = quiet_q;
`ifdef SPICE_NODE_CLAMP_FLAG_EN
    clamped_d  = clamped_q;
`endif

    slice_s = i_in[int'(idx_q)*`W +: `W];
    vn_s    = VW'(v_q) + VW'(delta_p1_q);
    v_new_s = clamp_v(vn_s);
    dv_s    = abs_v(VW'(v_new_s) - VW'(v_q));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCUM;
          acc_p0_d = '0;
          idx_d    = '0;
        end
      end

      // Stage p0: serial accumulate, one slice per cycle
      ACCUM: begin
        acc_p0_d = acc_p0_q + AW'(slice_s);
        idx_d    = idx_q + IW'(1);
        if (idx_q == IW'(N_IN - 1)) state_d = SCALE;
      end

      // Stage p1: capacitance scaling (floor division by 2**CAP_SHIFT)
      SCALE: begin
        delta_p1_d = acc_p0_q >>> CAP_SHIFT;
        state_d    = UPDATE;
      end

      // Stage p2: integrate, clamp, settle tracking
      UPDATE: begin
        v_d     = v_new_s;
        done_d  = 1'b1;
        state_d = IDLE;
        if (dv_s <= $signed(VW'(SETTLE_THRESH)))
          quiet_d = (quiet_q == CW'(SETTLE_COUNT)) ? quiet_q : quiet_q + CW'(1);
        else
          quiet_d = '0;
`ifdef SPICE_NODE_CLAMP_FLAG_EN
        if ((vn_s > HI_V) || (vn_s < LO_V)) clamped_d = 1'b1;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eclk) begin
    if (ereset) begin
      state_q   <= IDLE;
      acc_p0_q  <= '0;
      idx_q     <= '0;
      v_q       <= LO_W;
      done_q    <= 1'b0;
      quiet_q   <= '0;
`ifdef SPICE_NODE_CLAMP_FLAG_EN
      clamped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_p0_q  <= acc_p0_d;
      idx_q     <= idx_d;
      v_q       <= v_d;
      done_q    <= done_d;
      quiet_q   <= quiet_d;
`ifdef SPICE_NODE_CLAMP_FLAG_EN
      clamped_q <= clamped_d;
`endif
    end
  end

  // Scaled sum is pure data, consumed only in UPDATE after SCALE has written it.
  always_ff @(posedge eclk) begin
    delta_p1_q <= delta_p1_d;
  end

  assign ready   = (state_q == IDLE);
  assign v       = v_q;
  assign p       = ~v_q[`W-1];
  assign done    = done_q;
  assign settled = (quiet_q == CW'(SETTLE_COUNT));
`ifdef SPICE_NODE_CLAMP_FLAG_EN
  assign clamped = clamped_q;
`endif

endmodule
